mips_mc_controller: RTL and testbench

//   Parametrised multicycle control unit for the TinyMIPS core; successor to the fixed 8-bit, 4-beat controller.

---
 rtl/mips_mc_controller.sv | 195 +++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
// Multicycle control unit for the TinyMIPS core: width-scaled instruction fetch,
// mem_ready-stalled memory states, internal PC enable and a retired-instruction counter.
module mips_mc_controller #(
   parameter int WIDTH           = 8,
   parameter int INSTR_BITS      = 32,
   parameter int HALT_ON_ILLEGAL = 1,
   parameter int CNT_W           = 16,
   localparam int BEATS          = INSTR_BITS / WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       op,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             memread,
   output logic             memwrite,
   output logic             iord,
   output logic [BEATS-1:0] irwrite,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       aluop,
   output logic [1:0]       pcsource,
   output logic             pcen,
   output logic             regwrite,
   output logic             regdst,
   output logic             memtoreg,
   output logic             halted,
   output logic             instr_done,
   output logic [CNT_W-1:0] retire_count,
   output logic [3:0]       state_dbg
);

   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
   localparam logic [BEATS-1:0]  LANE0     = BEATS'(1);

   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      RTEX   = 4'd6,
      RTWB   = 4'd7,
      ADDIEX = 4'd8,
      ADDIWB = 4'd9,
      BEQEX  = 4'd10,
      JEX    = 4'd11,
      HALT   = 4'd12
   } state_t;

   state_t            state;
   logic [BEAT_W-1:0] beat;
   logic              pcwrite;
   logic              branch;
   logic              legal;

   assign state_dbg = state;
   assign legal = (op == OP_LB) || (op == OP_SB) || (op == OP_RTYPE) ||
                  (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= FETCH;
         beat         <= '0;
         retire_count <= '0;
      end else begin
         if (instr_done) retire_count <= retire_count + 1'b1;
         case (state)
            FETCH:
               if (mem_ready) begin
                  if (beat == BEAT_LAST) begin
                     state <= DECODE;
                     beat  <= '0;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            DECODE:
               case (op)
                  OP_LB, OP_SB: state <= MEMADR;
                  OP_RTYPE:     state <= RTEX;
                  OP_BEQ:       state <= BEQEX;
                  OP_J:         state <= JEX;
                  OP_ADDI:      state <= ADDIEX;
                  default:      state <= (HALT_ON_ILLEGAL != 0) ? HALT : FETCH;
               endcase
            // Only LB and SB reach MEMADR, so SB alone selects the write path.
            MEMADR: state <= (op == OP_SB) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state <= MEMWB;
            MEMWR:  if (mem_ready) state <= FETCH;
            RTEX:   state <= RTWB;
            ADDIEX: state <= ADDIWB;
            MEMWB, RTWB, ADDIWB, BEQEX, JEX: state <= FETCH;
            HALT:   state <= HALT;
            default: state <= FETCH;
         endcase
      end
   end

   always_comb begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = '0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsource   = 2'b00;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      halted     = 1'b0;
      instr_done = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      case (state)
         FETCH: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            if (mem_ready) begin
               irwrite = LANE0 << beat;
               pcwrite = 1'b1;
            end
         end
         DECODE: begin
            alusrcb = 2'b11;
            if (!legal && (HALT_ON_ILLEGAL == 0)) instr_done = 1'b1;
         end
         MEMADR, ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         MEMWB: begin
            regwrite   = 1'b1;
            memtoreg   = 1'b1;
            instr_done = 1'b1;
         end
         MEMWR: begin
            memwrite   = 1'b1;
            iord       = 1'b1;
            instr_done = mem_ready;
         end
         RTEX: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         RTWB: begin
            regwrite   = 1'b1;
            regdst     = 1'b1;
            instr_done = 1'b1;
         end
         ADDIWB: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         BEQEX: begin
            alusrca    = 1'b1;
            aluop      = 2'b01;
            pcsource   = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
         JEX: begin
            pcsource   = 2'b10;
            pcwrite    = 1'b1;
            instr_done = 1'b1;
         end
         HALT: halted = 1'b1;
         default: ;
      endcase
      pcen = pcwrite | (branch & zero);
      // A reset cycle must not commit anything: suppress every write strobe.
      if (rst) begin
         irwrite    = '0;
         pcen       = 1'b0;
         memwrite   = 1'b0;
         regwrite   = 1'b0;
         instr_done = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: a 4-beat halting build and a 2-beat
// NOP-on-illegal build with a narrow counter, checked cycle by cycle from a queue.
module tb_mips_mc_controller;

   localparam logic [5:0] LB   = 6'b100000;
   localparam logic [5:0] SB   = 6'b101000;
   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] BAD  = 6'b111111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b, mem_ready, zero;
   logic [5:0] op;

   logic        mr_a, mw_a, io_a, asa_a, pcen_a, rw_a, rd_a, m2r_a, h_a, dn_a;
   logic [3:0]  irw_a, st_a;
   logic [1:0]  asb_a, aop_a, ps_a;
   logic [15:0] rc_a;

   logic        mr_b, mw_b, io_b, asa_b, pcen_b, rw_b, rd_b, m2r_b, h_b, dn_b;
   logic [1:0]  irw_b;
   logic [3:0]  st_b;
   logic [1:0]  asb_b, aop_b, ps_b;
   logic [3:0]  rc_b;

   mips_mc_controller #(.WIDTH(8), .INSTR_BITS(32), .HALT_ON_ILLEGAL(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst_a), .op(op), .zero(zero), .mem_ready(mem_ready),
      .memread(mr_a), .memwrite(mw_a), .iord(io_a), .irwrite(irw_a), .alusrca(asa_a),
      .alusrcb(asb_a), .aluop(aop_a), .pcsource(ps_a), .pcen(pcen_a), .regwrite(rw_a),
      .regdst(rd_a), .memtoreg(m2r_a), .halted(h_a), .instr_done(dn_a),
      .retire_count(rc_a), .state_dbg(st_a));

   mips_mc_controller #(.WIDTH(16), .INSTR_BITS(32), .HALT_ON_ILLEGAL(0), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst_b), .op(op), .zero(zero), .mem_ready(mem_ready),
      .memread(mr_b), .memwrite(mw_b), .iord(io_b), .irwrite(irw_b), .alusrca(asa_b),
      .alusrcb(asb_b), .aluop(aop_b), .pcsource(ps_b), .pcen(pcen_b), .regwrite(rw_b),
      .regdst(rd_b), .memtoreg(m2r_b), .halted(h_b), .instr_done(dn_b),
      .retire_count(rc_b), .state_dbg(st_b));

   // Vector layout: memread memwrite iord irwrite[7:0] alusrca alusrcb aluop pcsource
   //                pcen regwrite regdst memtoreg halted instr_done
   logic [23:0] vec_a, vec_b;
   assign vec_a = {mr_a, mw_a, io_a, 4'b0, irw_a, asa_a, asb_a, aop_a, ps_a,
                   pcen_a, rw_a, rd_a, m2r_a, h_a, dn_a};
   assign vec_b = {mr_b, mw_b, io_b, 6'b0, irw_b, asa_b, asb_b, aop_b, ps_b,
                   pcen_b, rw_b, rd_b, m2r_b, h_b, dn_b};

   logic [23:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [15:0] cnt_a = 16'd0;
   logic [3:0]  cnt_b = 4'd0;
   logic        sel_b = 1'b0;

   function automatic logic [23:0] mk(input logic mr, mw, io, input logic [7:0] irw,
                                      input logic asa, input logic [1:0] asb, aop, ps,
                                      input logic pc, rw, rd, m2r, h, dn);
      return {mr, mw, io, irw, asa, asb, aop, ps, pc, rw, rd, m2r, h, dn};
   endfunction

   function automatic logic [23:0] e_fetch(input int b, input logic rdy);
      logic [7:0] lane;
      lane = rdy ? (8'd1 << b) : 8'd0;
      return mk(1, 0, 0, lane, 0, 2'b01, 2'b00, 2'b00, rdy, 0, 0, 0, 0, 0);
   endfunction
   function automatic logic [23:0] e_decode(input logic nop);
      return mk(0, 0, 0, 8'd0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 0, nop);
   endfunction
   function automatic logic [23:0] e_adr();   // MEMADR and ADDIEX
      return mk(0, 0, 0, 8'd0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic logic [23:0] e_memrd();
      return mk(1, 0, 1, 8'd0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic logic [23:0] e_memwb();
      return mk(0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 0, 1);
   endfunction
   function automatic logic [23:0] e_memwr(input logic rdy);
      return mk(0, 1, 1, 8'd0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, rdy);
   endfunction
   function automatic logic [23:0] e_rtex();
      return mk(0, 0, 0, 8'd0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic logic [23:0] e_wb(input logic rd);   // RTWB / ADDIWB
      return mk(0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00, 0, 1, rd, 0, 0, 1);
   endfunction
   function automatic logic [23:0] e_beq(input logic z);
      return mk(0, 0, 0, 8'd0, 1, 2'b00, 2'b01, 2'b01, z, 0, 0, 0, 0, 1);
   endfunction
   function automatic logic [23:0] e_jex();
      return mk(0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0, 0, 0, 1);
   endfunction
   function automatic logic [23:0] e_halt();
      return mk(0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
   endfunction

   task automatic check_vec(input string tag);
      logic [23:0] act, ex;
      act = sel_b ? vec_b : vec_a;
      ex  = exp_q.pop_front();
      checks++;
      assert (act === ex) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, act, ex);
      end
   endtask

   // One clock: drive inputs, queue the expected outputs, compare mid-cycle.
   task automatic cyc(input logic r, input logic rdy, input logic z, input logic [5:0] o,
                      input logic [23:0] e, input string tag);
      if (sel_b) rst_b = r; else rst_a = r;
      mem_ready = rdy;
      zero      = z;
      op        = o;
      exp_q.push_back(e);
      if (!r && e[0]) begin
         if (sel_b) cnt_b = cnt_b + 4'd1; else cnt_a = cnt_a + 16'd1;
      end
      @(negedge clk);
      check_vec(tag);
      @(posedge clk);
      #1;
      if (r) begin
         if (sel_b) cnt_b = 4'd0; else cnt_a = 16'd0;
      end
   endtask

   task automatic fetch(input int nb, input logic [5:0] o, input logic z);
      for (int b = 0; b < nb; b++) cyc(0, 1, z, o, e_fetch(b, 1), "fetch");
   endtask

   task automatic check_count(input string tag);
      logic [15:0] act, ex;
      act = sel_b ? {12'd0, rc_b} : rc_a;
      ex  = sel_b ? {12'd0, cnt_b} : cnt_a;
      checks++;
      assert (act === ex) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, act, ex);
      end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = RT;
      repeat (2) @(posedge clk);
      #1;
      rst_a = 1'b0;

      // Reset state
      checks++;
      assert (st_a === 4'd0) else begin
         errors++;
         $error("FAIL reset_state: observed %0d expected 0", st_a);
      end
      check_count("reset_count");
      cyc(0, 0, 0, RT, e_fetch(0, 0), "reset_outputs");

      // RTYPE with memory always ready
      fetch(4, RT, 0);
      cyc(0, 1, 0, RT, e_decode(0), "rt_decode");
      cyc(0, 1, 0, RT, e_rtex(), "rt_ex");
      cyc(0, 1, 0, RT, e_wb(1), "rt_wb");
      check_count("rt_count");

      // LB with a three-cycle read stall
      fetch(4, LB, 0);
      cyc(0, 1, 0, LB, e_decode(0), "lb_decode");
      cyc(0, 1, 0, LB, e_adr(), "lb_adr");
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, LB, e_memrd(), "lb_stall");
      cyc(0, 1, 0, LB, e_memrd(), "lb_rd_ready");
      cyc(0, 1, 0, LB, e_memwb(), "lb_wb");
      check_count("lb_count");

      // BEQ taken then not taken
      fetch(4, BEQ, 1);
      cyc(0, 1, 1, BEQ, e_decode(0), "beq_decode");
      cyc(0, 1, 1, BEQ, e_beq(1), "beq_taken");
      fetch(4, BEQ, 0);
      cyc(0, 1, 0, BEQ, e_decode(0), "beq_decode");
      cyc(0, 1, 0, BEQ, e_beq(0), "beq_not_taken");
      check_count("beq_count");

      // Illegal opcode halts until reset
      fetch(4, BAD, 0);
      cyc(0, 1, 0, BAD, e_decode(0), "bad_decode");
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, BAD, e_halt(), "halt_hold");
      cyc(1, 1, 0, BAD, e_halt(), "halt_rst_cycle");
      check_count("halt_rst_count");
      cyc(0, 0, 0, RT, e_fetch(0, 0), "halt_exit");

      // Reset mid-fetch (beat 2) and during a stalled store
      cyc(0, 1, 0, RT, e_fetch(0, 1), "f_beat0");
      cyc(0, 1, 0, RT, e_fetch(1, 1), "f_beat1");
      cyc(1, 1, 0, RT, e_fetch(2, 0), "rst_at_beat2");
      fetch(4, SB, 0);
      cyc(0, 1, 0, SB, e_decode(0), "sb_decode");
      cyc(0, 1, 0, SB, e_adr(), "sb_adr");
      for (int i = 0; i < 2; i++) cyc(0, 0, 0, SB, e_memwr(0), "sb_stall");
      cyc(1, 0, 0, SB, mk(0, 0, 1, 8'd0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0),
          "rst_in_memwr");
      fetch(4, SB, 0);
      cyc(0, 1, 0, SB, e_decode(0), "sb_decode");
      cyc(0, 1, 0, SB, e_adr(), "sb_adr");
      cyc(0, 0, 0, SB, e_memwr(0), "sb_wait");
      cyc(0, 1, 0, SB, e_memwr(1), "sb_done");
      check_count("sb_count");

      // 16-bit build: 2-beat fetch, NOP on illegal, 4-bit counter wrap
      rst_a = 1'b1;
      sel_b = 1'b1;
      cyc(1, 1, 0, JMP, e_fetch(0, 0), "b_rst_cycle");
      check_count("b_reset_count");
      fetch(2, JMP, 0);
      cyc(0, 1, 0, JMP, e_decode(0), "j_decode");
      cyc(0, 1, 0, JMP, e_jex(), "j_ex");
      fetch(2, ADDI, 0);
      cyc(0, 1, 0, ADDI, e_decode(0), "addi_decode");
      cyc(0, 1, 0, ADDI, e_adr(), "addi_ex");
      cyc(0, 1, 0, ADDI, e_wb(0), "addi_wb");
      fetch(2, BAD, 0);
      cyc(0, 1, 0, BAD, e_decode(1), "nop_decode");
      check_count("nop_count");
      for (int i = 0; i < 12; i++) begin
         fetch(2, JMP, 0);
         cyc(0, 1, 0, JMP, e_decode(0), "j_decode");
         cyc(0, 1, 0, JMP, e_jex(), "j_ex");
      end
      check_count("count_all_ones");
      checks++;
      assert (rc_b === 4'hF) else begin
         errors++;
         $error("FAIL count_ones_const: observed %h expected f", rc_b);
      end
      fetch(2, JMP, 0);
      cyc(0, 1, 0, JMP, e_decode(0), "j_decode");
      cyc(0, 1, 0, JMP, e_jex(), "j_ex_wrap");
      check_count("count_wrap");

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL queue_drained: observed %0d expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
